vm2413_reg_writer: RTL and testbench

- Translates CPU port writes (address latch / data write) into read-modify-write updates of the 9-entry, 24-bit per-channel register memory.
- Sits directly upstream of that memory. Shares the memory's single address port with the channel-scan engine, and takes the port only in cycles the engine releases via `cpu_slot`.
- Writes to non-channel registers (0x00–0x0F and unmapped addresses) are forwarded as a strobe for the instrument/rhythm logic.

---
 rtl/vm2413_reg_writer.sv | 109 ++++++++++
 tb/tb_vm2413_reg_writer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vm2413_reg_writer.sv
// vm2413_reg_writer: turns CPU address/data port writes into read-modify-write
// updates of the per-channel register memory, forwarding other writes to ext_*.
module vm2413_reg_writer #(
    parameter int NUM_CH    = 9,
    parameter int INIT_WAIT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wr,
    input  logic        io_a0,
    input  logic [7:0]  io_data,
    output logic        busy,
    output logic        overrun,
    input  logic        cpu_slot,
    input  logic [3:0]  engine_addr,
    output logic [3:0]  mem_addr,
    output logic        mem_wr,
    output logic [23:0] mem_wdata,
    input  logic [23:0] mem_rdata,
    output logic        ext_wr,
    output logic [7:0]  ext_addr,
    output logic [7:0]  ext_data
);
    typedef enum logic [2:0] {INIT, IDLE, RD, RDW, WR} state_t;

    localparam int CW = $clog2(INIT_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(INIT_WAIT - 1);
    localparam logic [4:0] CH_LIM = 5'(NUM_CH);

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [7:0] addr_reg;
    logic [3:0] ch_q;
    logic [1:0] grp_q;
    logic [7:0] data_q;
    logic [23:0] merged;
    logic is_chan, data_wr, chan_wr;

    // Channel registers live at 0x10/0x20/0x30 + ch; everything else goes out as ext.
    assign is_chan = addr_reg[7:6] == 2'b00 && addr_reg[5:4] != 2'b00 &&
                     {1'b0, addr_reg[3:0]} < CH_LIM;
    assign data_wr = io_wr & io_a0;
    assign chan_wr = data_wr & is_chan;
    assign busy    = state != IDLE;

    // Group 2 maps d[5:0] straight onto {sus, key, blk, fnum[8]}; bits 23:22 are forced to 0.
    assign merged = grp_q == 2'd1 ? {2'b00, mem_rdata[21:8], data_q} :
                    grp_q == 2'd2 ? {2'b00, mem_rdata[21:14], data_q[5:0], mem_rdata[7:0]} :
                                    {2'b00, data_q, mem_rdata[13:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = engine_addr;
        mem_wr    = 1'b0;
        case (state)
            INIT: state_nxt = cnt == CNT_LAST ? IDLE : INIT;
            IDLE: state_nxt = chan_wr ? RD : IDLE;
            RD: begin
                mem_addr  = cpu_slot ? ch_q : engine_addr;
                state_nxt = cpu_slot ? RDW : RD;
            end
            RDW: state_nxt = WR;
            WR: begin
                mem_addr  = cpu_slot ? ch_q : engine_addr;
                mem_wr    = cpu_slot;
                state_nxt = cpu_slot ? IDLE : WR;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            addr_reg  <= '0;
            ch_q      <= '0;
            grp_q     <= '0;
            data_q    <= '0;
            mem_wdata <= '0;
            overrun   <= 1'b0;
            ext_wr    <= 1'b0;
            ext_addr  <= '0;
            ext_data  <= '0;
        end else begin
            cnt    <= state == INIT ? cnt + 1'b1 : '0;
            ext_wr <= data_wr & ~is_chan;
            if (io_wr && !io_a0)
                addr_reg <= io_data;
            if (chan_wr && !busy) begin
                ch_q   <= addr_reg[3:0];
                grp_q  <= addr_reg[5:4];
                data_q <= io_data;
            end
            if (state == RDW)
                mem_wdata <= merged;
            if (chan_wr && busy)
                overrun <= 1'b1;
            if (data_wr && !is_chan) begin
                ext_addr <= addr_reg;
                ext_data <= io_data;
            end
        end
    end
endmodule

// File: tb/tb_vm2413_reg_writer.sv
// tb_vm2413_reg_writer: directed checks of the register writer against a
// registered-read memory model and hand-computed channel words.
module tb_vm2413_reg_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_wr = 1'b0;
    logic        io_a0 = 1'b0;
    logic [7:0]  io_data = '0;
    logic        busy, overrun;
    logic        cpu_slot = 1'b1;
    logic [3:0]  engine_addr = 4'hA;
    logic [3:0]  mem_addr;
    logic        mem_wr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata = '0;
    logic        ext_wr;
    logic [7:0]  ext_addr, ext_data;

    logic [23:0] mem [16];
    int          wr_count = 0;
    logic        pre_en = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [23:0] pre_val = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_snap;

    vm2413_reg_writer dut (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_a0(io_a0), .io_data(io_data),
        .busy(busy), .overrun(overrun), .cpu_slot(cpu_slot), .engine_addr(engine_addr),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_data(ext_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (pre_en)
            mem[pre_addr] <= pre_val;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [23:0] v);
        pre_en = 1'b1;
        pre_addr = a;
        pre_val = v;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic cpu_write(input logic a0, input logic [7:0] d);
        io_wr = 1'b1;
        io_a0 = a0;
        io_data = d;
        tick();
        io_wr = 1'b0;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        cpu_write(1'b0, a);
        cpu_write(1'b1, d);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) tick();
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        #1;
        for (int i = 0; i < 16; i++) preload(4'(i), 24'h0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_ext_wr", {31'd0, ext_wr}, 32'd0);
        check("rst_ext_addr", {24'd0, ext_addr}, 32'h0);
        check("rst_ext_data", {24'd0, ext_data}, 32'h0);
        check("rst_wdata", {8'd0, mem_wdata}, 32'h0);

        // Writes during the post-reset wait are dropped as overruns
        reset = 1'b1;
        repeat (2) tick();
        reg_write(8'h30, 8'hA5);
        check("init_overrun", {31'd0, overrun}, 32'd1);
        repeat (5) tick();
        check("init_busy_c9", {31'd0, busy}, 32'd1);
        tick();
        check("init_busy_c10", {31'd0, busy}, 32'd0);
        check("init_no_wr", wr_count, 0);

        do_reset();
        check("overrun_clear", {31'd0, overrun}, 32'd0);
        reg_write(8'h15, 8'h34);
        check("lat_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        tick();
        check("lat_wr_c3", {31'd0, mem_wr}, 32'd1);
        check("lat_addr_c3", {28'd0, mem_addr}, 32'd5);
        check("fnum_wdata", {8'd0, mem_wdata}, 32'h000034);
        tick();
        check("lat_busy_c4", {31'd0, busy}, 32'd0);
        check("fnum_mem", {8'd0, mem[5]}, 32'h000034);
        reg_write(8'h25, 8'h1B);
        wait_idle("key_idle");
        check("key_mem", {8'd0, mem[5]}, 32'h001B34);

        preload(4'd2, 24'h3FFFFF);
        reg_write(8'h32, 8'h00);
        tick();
        tick();
        check("pres_wdata", {8'd0, mem_wdata}, 32'h003FFF);
        wait_idle("pres_idle");
        check("pres_mem", {8'd0, mem[2]}, 32'h003FFF);

        preload(4'd3, 24'h123456);
        engine_addr = 4'd7;
        cpu_slot = 1'b0;
        reg_write(8'h13, 8'h77);
        for (int i = 0; i < 20; i++) begin
            check("starve_addr", {28'd0, mem_addr}, 32'd7);
            check("starve_wr", {31'd0, mem_wr}, 32'd0);
            tick();
        end
        check("starve_busy", {31'd0, busy}, 32'd1);
        cpu_slot = 1'b1;
        wait_idle("starve_idle");
        check("starve_mem", {8'd0, mem[3]}, 32'h123477);

        // Ext write lands while the ch1 RMW is in flight and retargets the address register
        reg_write(8'h31, 8'h5A);
        reg_write(8'h0E, 8'h20);
        check("ext_wr", {31'd0, ext_wr}, 32'd1);
        check("ext_addr", {24'd0, ext_addr}, 32'h0E);
        check("ext_data", {24'd0, ext_data}, 32'h20);
        check("ext_busy_wr", {31'd0, mem_wr}, 32'd1);
        check("ext_busy_addr", {28'd0, mem_addr}, 32'd1);
        check("ext_busy_wdata", {8'd0, mem_wdata}, 32'h168000);
        tick();
        check("ext_wr_pulse", {31'd0, ext_wr}, 32'd0);
        check("ext_overrun", {31'd0, overrun}, 32'd0);
        check("ext_rmw_mem", {8'd0, mem[1]}, 32'h168000);

        reg_write(8'h18, 8'hFF);
        wait_idle("ch8_idle");
        check("ch8_mem", {8'd0, mem[8]}, 32'h0000FF);
        wr_snap = wr_count;
        reg_write(8'h19, 8'h55);
        check("ch9_ext_wr", {31'd0, ext_wr}, 32'd1);
        check("ch9_ext_addr", {24'd0, ext_addr}, 32'h19);
        check("ch9_ext_data", {24'd0, ext_data}, 32'h55);
        check("ch9_busy", {31'd0, busy}, 32'd0);
        tick();
        check("ch9_no_wr", wr_count, wr_snap);

        reg_write(8'h14, 8'h11);
        tick();
        tick();
        cpu_write(1'b1, 8'h22);
        check("wrdone_overrun", {31'd0, overrun}, 32'd1);
        check("wrdone_busy", {31'd0, busy}, 32'd0);
        check("wrdone_mem", {8'd0, mem[4]}, 32'h000011);

        preload(4'd6, 24'hABCDEF);
        reg_write(8'h16, 8'h00);
        tick();
        wr_snap = wr_count;
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd1);
        check("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("midrst_wdata", {8'd0, mem_wdata}, 32'h0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (12) tick();
        check("midrst_no_wr", wr_count, wr_snap);
        check("midrst_mem", {8'd0, mem[6]}, 32'hABCDEF);
        check("midrst_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
